vga_out_stage: RTL and testbench

- Parametrised pixel output stage that replaces the fixed single-register RGB buffer at the display top.
- Delays sync and video-enable to match a configurable pixel-generator latency, then registers RGB and syncs together on the pixel tick.
- Forces black during blanking, applies the selected sync polarity, and keeps a frame counter with a frame-start pulse for game logic.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/tick_delay_line.sv | 32 +++
 rtl/vga_out_stage.sv | 94 +++++++++
 tb/tb_vga_out_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, RGB payload type and sync-level helper for the display pipeline.
package vga_pkg;

  // 640x480 @ 60 Hz timing, in pixels / lines
  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned COLOR_W_DEF = 12;
  localparam int unsigned CH_W_DEF    = COLOR_W_DEF / 3;

  typedef struct packed {
    logic [CH_W_DEF-1:0] r;
    logic [CH_W_DEF-1:0] g;
    logic [CH_W_DEF-1:0] b;
  } rgb_t;

  // Internal sync levels are always active-high
  localparam logic SYNC_ASSERT = 1'b1;
  localparam logic SYNC_IDLE   = 1'b0;

  function automatic logic sync_level(input logic active, input bit active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/tick_delay_line.sv
// WIDTH x DEPTH shift register advanced by an enable; DEPTH = 0 degenerates to a wire.
module tick_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, reset, en};
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_out_stage.sv
// Pixel output stage: aligns sync/video_on with pixel-generator latency, blanks, sets sync
// polarity, counts frames. Optional colour-bar generator under VGA_OUT_TEST_PAT_EN.
module vga_out_stage
  import vga_pkg::*;
#(
  parameter int unsigned COLOR_W         = COLOR_W_DEF,
  parameter int unsigned PIX_LAT         = 1,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned FRAME_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_tick,
`ifdef VGA_OUT_TEST_PAT_EN
  input  logic               test_en,
`endif
  input  logic               video_on_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               hsync,
  output logic               vsync,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               frame_start
);

  logic [2:0]         ctl_d;
  logic               video_on_d;
  logic               hsync_d;
  logic               vsync_d;
  logic               vsync_prev;
  logic [COLOR_W-1:0] rgb_sel_c;

  tick_delay_line #(
    .WIDTH (3),
    .DEPTH (PIX_LAT)
  ) u_ctl_dly (
    .clk   (clk),
    .reset (reset),
    .en    (p_tick),
    .d     ({video_on_in, hsync_in, vsync_in}),
    .q     (ctl_d)
  );

  assign {video_on_d, hsync_d, vsync_d} = ctl_d;

`ifdef VGA_OUT_TEST_PAT_EN
  localparam int unsigned CH_W = COLOR_W / 3;

  logic [9:0] act_cnt;
  logic [2:0] bar_c;

  // Position within the active run; restarts at every blanking tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_cnt <= '0;
    end else if (p_tick) begin
      act_cnt <= video_on_d ? act_cnt + 10'(1) : '0;
    end
  end

  assign bar_c     = act_cnt[9:7];
  assign rgb_sel_c = test_en ? {{CH_W{bar_c[2]}}, {CH_W{bar_c[1]}}, {CH_W{bar_c[0]}}}
                             : rgb_in;
`else
  assign rgb_sel_c = rgb_in;
`endif

  // Output register; frame_start is the only state that moves without p_tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_out     <= '0;
      hsync       <= sync_level(SYNC_IDLE, SYNC_ACTIVE_LOW);
      vsync       <= sync_level(SYNC_IDLE, SYNC_ACTIVE_LOW);
      vsync_prev  <= SYNC_IDLE;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (p_tick) begin
        rgb_out    <= video_on_d ? rgb_sel_c : '0;
        hsync      <= sync_level(hsync_d, SYNC_ACTIVE_LOW);
        vsync      <= sync_level(vsync_d, SYNC_ACTIVE_LOW);
        vsync_prev <= vsync_d;
        if (vsync_d && !vsync_prev) begin
          frame_cnt   <= frame_cnt + FRAME_W'(1);
          frame_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_out_stage.sv
// Directed bench for vga_out_stage: default build plus wrap (FRAME_W=2) and
// active-high/PIX_LAT=0 instances sharing the same stimulus.
module tb_vga_out_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        video_on_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [11:0] rgb_in;
`ifdef VGA_OUT_TEST_PAT_EN
  logic        test_en;
`endif

  logic [11:0] rgb_a, rgb_w, rgb_p;
  logic        hs_a, vs_a, fs_a;
  logic        hs_w, vs_w, fs_w;
  logic        hs_p, vs_p, fs_p;
  logic [7:0]  fc_a, fc_p;
  logic [1:0]  fc_w;

  int n_cmp = 0;
  int n_bad = 0;
  int fs_seen = 0;

  always #5 clk = ~clk;

  vga_out_stage dut (
    .clk (clk), .reset (reset), .p_tick (p_tick),
`ifdef VGA_OUT_TEST_PAT_EN
    .test_en (test_en),
`endif
    .video_on_in (video_on_in), .hsync_in (hsync_in), .vsync_in (vsync_in),
    .rgb_in (rgb_in), .rgb_out (rgb_a), .hsync (hs_a), .vsync (vs_a),
    .frame_cnt (fc_a), .frame_start (fs_a)
  );

  vga_out_stage #(.FRAME_W (2)) dut_w (
    .clk (clk), .reset (reset), .p_tick (p_tick),
`ifdef VGA_OUT_TEST_PAT_EN
    .test_en (1'b0),
`endif
    .video_on_in (video_on_in), .hsync_in (hsync_in), .vsync_in (vsync_in),
    .rgb_in (rgb_in), .rgb_out (rgb_w), .hsync (hs_w), .vsync (vs_w),
    .frame_cnt (fc_w), .frame_start (fs_w)
  );

  vga_out_stage #(.PIX_LAT (0), .SYNC_ACTIVE_LOW (1'b0)) dut_p (
    .clk (clk), .reset (reset), .p_tick (p_tick),
`ifdef VGA_OUT_TEST_PAT_EN
    .test_en (1'b0),
`endif
    .video_on_in (video_on_in), .hsync_in (hsync_in), .vsync_in (vsync_in),
    .rgb_in (rgb_in), .rgb_out (rgb_p), .hsync (hs_p), .vsync (vs_p),
    .frame_cnt (fc_p), .frame_start (fs_p)
  );

  // frame_start pulses of the wrap instance, one count per clk they are high
  always @(posedge clk) if (fs_w === 1'b1) fs_seen <= fs_seen + 1;

  task automatic tick();
    p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    video_on_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = 12'h000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    video_on_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 12'hFFF;
    repeat (3) begin
      tick();
      hsync_in = ~hsync_in; vsync_in = ~vsync_in; rgb_in = ~rgb_in;
    end
    n_cmp++; if (rgb_a !== 12'h000) begin n_bad++; $display("FAIL reset_rgb: got %h expected 000", rgb_a); end
    n_cmp++; if (hs_a !== 1'b1) begin n_bad++; $display("FAIL reset_hsync: got %b expected 1", hs_a); end
    n_cmp++; if (vs_a !== 1'b1) begin n_bad++; $display("FAIL reset_vsync: got %b expected 1", vs_a); end
    n_cmp++; if (fc_a !== 8'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d expected 0", fc_a); end
    n_cmp++; if (fs_a !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start: got %b expected 0", fs_a); end
    n_cmp++; if (hs_p !== 1'b0) begin n_bad++; $display("FAIL reset_hsync_ahigh: got %b expected 0", hs_p); end
    // release with live inputs: first tick still shows the cleared delay stage
    video_on_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b0; rgb_in = 12'hFFF;
    reset = 1'b1;
    tick();
    n_cmp++; if (rgb_a !== 12'h000) begin n_bad++; $display("FAIL release_rgb: got %h expected 000", rgb_a); end
    n_cmp++; if (hs_a !== 1'b1) begin n_bad++; $display("FAIL release_hsync: got %b expected 1", hs_a); end
    n_cmp++; if (rgb_p !== 12'hFFF) begin n_bad++; $display("FAIL release_rgb_lat0: got %h expected fff", rgb_p); end
    tick();
    n_cmp++; if (rgb_a !== 12'hFFF) begin n_bad++; $display("FAIL release_rgb_2: got %h expected fff", rgb_a); end
    n_cmp++; if (hs_a !== 1'b0) begin n_bad++; $display("FAIL release_hsync_2: got %b expected 0", hs_a); end
    idle_inputs();
    repeat (2) tick();
    n_cmp++; if (rgb_a !== 12'h000) begin n_bad++; $display("FAIL release_flush: got %h expected 000", rgb_a); end
  endtask

  task automatic test_alignment();
    video_on_in = 1'b1; hsync_in = 1'b1; rgb_in = 12'h123;
    tick();
    n_cmp++; if (rgb_a !== 12'h000) begin n_bad++; $display("FAIL align_n_rgb: got %h expected 000", rgb_a); end
    n_cmp++; if (hs_a !== 1'b1) begin n_bad++; $display("FAIL align_n_hsync: got %b expected 1", hs_a); end
    hsync_in = 1'b0; rgb_in = 12'hF0A;
    tick();
    n_cmp++; if (rgb_a !== 12'hF0A) begin n_bad++; $display("FAIL align_n1_rgb: got %h expected f0a", rgb_a); end
    n_cmp++; if (hs_a !== 1'b0) begin n_bad++; $display("FAIL align_n1_hsync: got %b expected 0", hs_a); end
    video_on_in = 1'b0; rgb_in = 12'h555;
    tick();
    n_cmp++; if (rgb_a !== 12'h555) begin n_bad++; $display("FAIL align_n2_rgb: got %h expected 555", rgb_a); end
    n_cmp++; if (hs_a !== 1'b1) begin n_bad++; $display("FAIL align_n2_hsync: got %b expected 1", hs_a); end
    rgb_in = 12'h777;
    tick();
    n_cmp++; if (rgb_a !== 12'h000) begin n_bad++; $display("FAIL align_n3_rgb: got %h expected 000", rgb_a); end
    idle_inputs();
    tick();
  endtask

  task automatic test_blanking();
    video_on_in = 1'b0; rgb_in = 12'hFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (rgb_a !== 12'h000) begin n_bad++; $display("FAIL blank_rgb[%0d]: got %h expected 000", i, rgb_a); end
    end
    video_on_in = 1'b1; hsync_in = 1'b1; rgb_in = 12'hABC;
    repeat (2) tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (rgb_a !== 12'hABC) begin n_bad++; $display("FAIL freeze_rgb[%0d]: got %h expected abc", i, rgb_a); end
      n_cmp++; if (hs_a !== 1'b0) begin n_bad++; $display("FAIL freeze_hsync[%0d]: got %b expected 0", i, hs_a); end
    end
    repeat (2) tick();
    n_cmp++; if (rgb_a !== 12'h000) begin n_bad++; $display("FAIL unfreeze_rgb: got %h expected 000", rgb_a); end
  endtask

  task automatic test_polarity();
    idle_inputs();
    tick();
    n_cmp++; if (hs_p !== 1'b0) begin n_bad++; $display("FAIL pol_idle: got %b expected 0", hs_p); end
    hsync_in = 1'b1; video_on_in = 1'b1; rgb_in = 12'h321;
    tick();
    n_cmp++; if (hs_p !== 1'b1) begin n_bad++; $display("FAIL pol_pulse: got %b expected 1", hs_p); end
    n_cmp++; if (rgb_p !== 12'h321) begin n_bad++; $display("FAIL pol_rgb: got %h expected 321", rgb_p); end
    idle_inputs();
    tick();
    n_cmp++; if (hs_p !== 1'b0) begin n_bad++; $display("FAIL pol_after: got %b expected 0", hs_p); end
    tick();
  endtask

  task automatic test_frame_wrap();
    logic [1:0] exp_w [5];
    int base;
    exp_w[0] = 2'd1; exp_w[1] = 2'd2; exp_w[2] = 2'd3; exp_w[3] = 2'd0; exp_w[4] = 2'd1;
    base = fs_seen;
    for (int k = 0; k < 5; k++) begin
      vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
      repeat (2) tick();
      n_cmp++; if (fc_w !== exp_w[k]) begin n_bad++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", k, fc_w, exp_w[k]); end
    end
    n_cmp++; if (fs_seen - base !== 5) begin n_bad++; $display("FAIL wrap_pulses: got %0d expected 5", fs_seen - base); end
    n_cmp++; if (fc_a !== 8'd5) begin n_bad++; $display("FAIL frame_cnt8: got %0d expected 5", fc_a); end
    n_cmp++; if (fc_p !== 8'd5) begin n_bad++; $display("FAIL frame_cnt_lat0: got %0d expected 5", fc_p); end
  endtask

`ifdef VGA_OUT_TEST_PAT_EN
  task automatic test_pattern();
    logic [2:0]  idx;
    logic [11:0] exp;
    test_en = 1'b1;
    video_on_in = 1'b1;
    rgb_in = 12'h5A5;
    tick();
    for (int p = 0; p < 1024; p++) begin
      rgb_in = 12'($urandom);
      if (p == 1023) video_on_in = 1'b0;
      tick();
      idx = 3'(p >> 7);
      exp = {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
      n_cmp++; if (rgb_a !== exp) begin n_bad++; $display("FAIL pattern[%0d]: got %h expected %h", p, rgb_a, exp); end
    end
    tick();
    n_cmp++; if (rgb_a !== 12'h000) begin n_bad++; $display("FAIL pattern_blank: got %h expected 000", rgb_a); end
    test_en = 1'b0;
    idle_inputs();
  endtask
`endif

  initial begin
    reset = 1'b0;
    p_tick = 1'b0;
`ifdef VGA_OUT_TEST_PAT_EN
    test_en = 1'b0;
`endif
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_alignment();
    test_blanking();
    test_polarity();
    test_frame_wrap();
`ifdef VGA_OUT_TEST_PAT_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
